ib_ram_page_loader: RTL and testbench
=====================================

// Module: ib_ram_page_loader
// PURPOSE
//  Iteration-refresh sequencer upstream of the row VNU/DNU datapath. On each decoding-iteration boundary it
//  streams that iteration's IB LUT pages from the IB-ROMs into the VNU-F0, VNU-F1 and DNU IB-RAMs.
//  It drives their page addresses, write data and write enables. Two banks alternate, so the next
//  iteration's LUTs are written into one bank while the datapath reads the other.
// PARAMETERS
//  ITER_ADDR_BW     5   iteration-index width (max 2^5 = 32 iterations)
//  VN_ROM_RD_BW     8   VN IB-ROM/RAM data width
//  VN_PAGE_ADDR_BW  6   VN page address width (N_VN = 64 pages per iteration)
//  VN_ROM_ADDR_BW  11   = ITER_ADDR_BW+VN_PAGE_ADDR_BW; elaboration error otherwise
//  DN_ROM_RD_BW     2   DN IB-ROM/RAM data width
//  DN_PAGE_ADDR_BW  6   DN page address width (N_DN = 2^DN_PAGE_ADDR_BW, must be <= N_VN)
//  DN_ROM_ADDR_BW  11   = ITER_ADDR_BW+DN_PAGE_ADDR_BW
//  ROM_RD_LATENCY   2   IB-ROM address-to-data latency in cycles (>=1)
// PORTS
//  write_clk         in   1                  single clock (VN and DN write domains are merged here)
//  rst               in   1                  synchronous, active-high reset
//  load_req          in   1                  pulse: start refresh for load_iter
//  load_iter         in   ITER_ADDR_BW       iteration index, sampled with load_req
//  load_busy         out  1                  refresh in progress
//  load_done         out  1                  1-cycle pulse: refresh complete, bank swapped
//  rd_bank           out  1                  bank the datapath must read
//  vn_rom_addr_0/1   out  VN_ROM_ADDR_BW     {iter,page} to VNU-F0/F1 IB-ROMs
//  dn_rom_addr_2     out  DN_ROM_ADDR_BW     {iter,page} to DNU IB-ROM
//  vn_rom_data_0/1   in   VN_ROM_RD_BW       ROM read data
//  dn_rom_data_2     in   DN_ROM_RD_BW       ROM read data
//  page_addr_ram_0/1 out  VN_PAGE_ADDR_BW+1  {wr_bank,page} to VNU IB-RAMs
//  page_addr_ram_2   out  DN_PAGE_ADDR_BW+1  {wr_bank,page} to DNU IB-RAM
//  ram_write_dataA_0/1 out VN_ROM_RD_BW      write data; ram_write_dataA_2 out DN_ROM_RD_BW
//  ib_ram_we         out  3                  [0]=VNU-F0, [1]=VNU-F1, [2]=DNU
// BEHAVIOUR
//  Reset: state IDLE. load_busy=0, load_done=0, rd_bank=0, ib_ram_we=0. All addresses and data = 0.
//  FSM IDLE->LOAD->DRAIN->DONE->IDLE:
//   IDLE:  on load_req=1, capture load_iter into iter_q and set page=0. Next state is LOAD.
//   LOAD:  page counts from 0 to N_VN-1, one per cycle, and the ROM addresses are {iter_q,page}.
//          On page==N_VN-1 go to DRAIN. DN address holds at N_DN-1 once page >= N_DN.
//   DRAIN: wait ROM_RD_LATENCY cycles, then go to DONE.
//   DONE:  load_done=1 for one cycle and rd_bank<=~rd_bank. Next state is IDLE.
//  Alignment: page, a per-port valid bit and wr_bank=~rd_bank are delayed ROM_RD_LATENCY cycles.
//   ib_ram_we[i] is high exactly in the cycle the ROM data for that page is presented on ram_write_dataA_i.
//   ib_ram_we[2] is high only for pages < N_DN.
//  Timing (req sampled at edge k): page p is written in cycle k+1+p+L. load_busy is high k+1..k+N_VN+L+1.
//   load_done is high in cycle k+N_VN+L+1.
//  A load_req while load_busy=1 is ignored, and the current load continues unchanged.
//  load_req in the DONE cycle is also ignored. Bank swap and new request never coincide.
//  Writes never target rd_bank. rd_bank changes only in DONE.
//  rst mid-load: ib_ram_we=0 from the next cycle, the delay line is flushed and no load_done is issued.
//   rd_bank returns to 0.
//  load_iter wraps naturally. No range check is done; ROM contents beyond the last iteration are don't-care.
// CONFIGURATION
//  IB_LOADER_OVERRUN_CNT_EN defined: adds output ovr_cnt[7:0].
//   ovr_cnt is a saturating count (stops at 255) of load_req pulses ignored while busy. It is cleared by rst.
//  Not defined: the port and counter are absent, and ignored requests are silently dropped.
// STRUCTURE
//  Shared package ib_loader_pkg: FSM state encoding (IDLE/LOAD/DRAIN/DONE) and ROM_RD_LATENCY default.
//   It also holds the bank-select bit position in page_addr_ram (MSB).
//  Sub-module ib_rom_rd_align: parameterised ROM_RD_LATENCY-deep shift register carrying {valid[2:0],bank,page}.
//   Instantiated once.
// TESTING (N_VN=N_DN=64, L=2 unless noted)
//  1. rst, then load_req@0 with iter=3: ROM addr 0x0C0..0x0FF.
//     ib_ram_we=3'b111 in cycles 3..66, page_addr_ram MSB=1, load_done@67, rd_bank=1 @68.
//  2. Second load with iter=4 after test 1: writes go to bank 0. ROM addr 0x100..0x13F. rd_bank returns to 0.
//  3. DN_PAGE_ADDR_BW=4: ib_ram_we[2] high only in cycles 3..18. we[1:0] still high 3..66.
//  4. load_req pulses @10 and @67 during busy: both ignored, exactly one load_done.
//     With IB_LOADER_OVERRUN_CNT_EN, ovr_cnt=2.
//  5. rst asserted @30 mid-load: ib_ram_we=0 from 31, no load_done, rd_bank=0, load_busy=0.
//  6. ROM_RD_LATENCY=1 and =4: scoreboard checks every RAM word equals ROM[{iter,page}]. No missing or duplicate writes.

Source files
------------

// File: rtl/ib_loader_pkg.sv
// ib_loader_pkg: shared FSM encoding, default ROM read latency and bank-bit position for the IB page loader
package ib_loader_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  localparam int ROM_RD_LATENCY_DEF = 2;
  // The bank select sits in the MSB of page_addr_ram, directly above the page index.
  function automatic int bank_bit(input int page_bw);
    return page_bw;
  endfunction
endpackage

// File: rtl/ib_rom_rd_align.sv
// ib_rom_rd_align: LAT-deep shift register aligning {valid,bank,page} with IB-ROM read data
//  clk, rst : clock, synchronous active-high reset (flushes every stage)
//  d        : word launched alongside the ROM address
//  q        : the same word LAT cycles later, coincident with the ROM data
module ib_rom_rd_align #(
  parameter int W   = 10,
  parameter int LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] sr [LAT];
  always_ff @(posedge clk)
    if (rst) sr <= '{default: '0};
    else begin
      sr[0] <= d;
      for (int i = 1; i < LAT; i++) sr[i] <= sr[i-1];
    end
  assign q = sr[LAT-1];
endmodule

// File: rtl/ib_ram_page_loader.sv
// ib_ram_page_loader: per-iteration refresh of VNU-F0/F1 and DNU IB-RAM pages from IB-ROMs, double-banked
//  write_clk, rst        : clock, synchronous active-high reset
//  load_req, load_iter   : start a refresh for load_iter (ignored while load_busy)
//  load_busy, load_done  : refresh in progress / one-cycle completion pulse (bank swapped)
//  rd_bank               : bank the datapath reads; writes always go to the other bank
//  vn_rom_addr_0/1, dn_rom_addr_2 : {iter,page} to the IB-ROMs; *_rom_data_* : ROM read data
//  page_addr_ram_0/1/2   : {wr_bank,page} to the IB-RAMs; ram_write_dataA_0/1/2 : write data
//  ib_ram_we             : [0]=VNU-F0, [1]=VNU-F1, [2]=DNU write enables
//  ovr_cnt               : saturating count of ignored requests, only with IB_LOADER_OVERRUN_CNT_EN
module ib_ram_page_loader
  import ib_loader_pkg::*;
#(
  parameter int ITER_ADDR_BW    = 5,
  parameter int VN_ROM_RD_BW    = 8,
  parameter int VN_PAGE_ADDR_BW = 6,
  parameter int VN_ROM_ADDR_BW  = 11,
  parameter int DN_ROM_RD_BW    = 2,
  parameter int DN_PAGE_ADDR_BW = 6,
  parameter int DN_ROM_ADDR_BW  = 11,
  parameter int ROM_RD_LATENCY  = ROM_RD_LATENCY_DEF
) (
  input  logic                       write_clk,
  input  logic                       rst,
  input  logic                       load_req,
  input  logic [ITER_ADDR_BW-1:0]    load_iter,
  output logic                       load_busy,
  output logic                       load_done,
  output logic                       rd_bank,
  output logic [VN_ROM_ADDR_BW-1:0]  vn_rom_addr_0,
  output logic [VN_ROM_ADDR_BW-1:0]  vn_rom_addr_1,
  output logic [DN_ROM_ADDR_BW-1:0]  dn_rom_addr_2,
  input  logic [VN_ROM_RD_BW-1:0]    vn_rom_data_0,
  input  logic [VN_ROM_RD_BW-1:0]    vn_rom_data_1,
  input  logic [DN_ROM_RD_BW-1:0]    dn_rom_data_2,
  output logic [VN_PAGE_ADDR_BW:0]   page_addr_ram_0,
  output logic [VN_PAGE_ADDR_BW:0]   page_addr_ram_1,
  output logic [DN_PAGE_ADDR_BW:0]   page_addr_ram_2,
  output logic [VN_ROM_RD_BW-1:0]    ram_write_dataA_0,
  output logic [VN_ROM_RD_BW-1:0]    ram_write_dataA_1,
  output logic [DN_ROM_RD_BW-1:0]    ram_write_dataA_2,
  output logic [2:0]                 ib_ram_we
`ifdef IB_LOADER_OVERRUN_CNT_EN
  ,output logic [7:0]                ovr_cnt
`endif
);
  localparam int N_DN = 2 ** DN_PAGE_ADDR_BW;
  localparam int CW   = $clog2(ROM_RD_LATENCY + 1);

  if (VN_ROM_ADDR_BW != ITER_ADDR_BW + VN_PAGE_ADDR_BW) begin : g_vn_bw_err
    $error("VN_ROM_ADDR_BW must equal ITER_ADDR_BW+VN_PAGE_ADDR_BW");
  end
  if (DN_ROM_ADDR_BW != ITER_ADDR_BW + DN_PAGE_ADDR_BW) begin : g_dn_bw_err
    $error("DN_ROM_ADDR_BW must equal ITER_ADDR_BW+DN_PAGE_ADDR_BW");
  end
  if (DN_PAGE_ADDR_BW > VN_PAGE_ADDR_BW || ROM_RD_LATENCY < 1) begin : g_cfg_err
    $error("need DN_PAGE_ADDR_BW <= VN_PAGE_ADDR_BW and ROM_RD_LATENCY >= 1");
  end

  state_t                     state;
  logic [ITER_ADDR_BW-1:0]    iter_q;
  logic [VN_PAGE_ADDR_BW-1:0] page;
  logic [CW-1:0]              cnt;
  logic                       ld;
  logic                       dn_in;
  logic                       bank_d;
  logic [VN_PAGE_ADDR_BW-1:0] page_d;

  always_ff @(posedge write_clk)
    if (rst) begin
      state     <= IDLE;
      iter_q    <= '0;
      page      <= '0;
      cnt       <= '0;
      load_busy <= 1'b0;
      load_done <= 1'b0;
      rd_bank   <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (state)
        IDLE:
          if (load_req) begin
            state     <= LOAD;
            iter_q    <= load_iter;
            page      <= '0;
            load_busy <= 1'b1;
          end
        LOAD:
          if (page == '1) begin
            state <= DRAIN;
            cnt   <= '0;
          end else page <= page + VN_PAGE_ADDR_BW'(1);
        DRAIN:
          if (cnt == CW'(ROM_RD_LATENCY - 1)) begin
            state     <= DONE;
            load_done <= 1'b1;
          end else cnt <= cnt + CW'(1);
        DONE: begin
          state     <= IDLE;
          rd_bank   <= ~rd_bank;
          load_busy <= 1'b0;
        end
      endcase
    end

  assign ld    = state == LOAD;
  assign dn_in = {1'b0, page} < (VN_PAGE_ADDR_BW + 1)'(N_DN);

  // The DN address parks on its last page once the VN sweep runs past N_DN.
  assign vn_rom_addr_0 = {iter_q, page};
  assign vn_rom_addr_1 = {iter_q, page};
  assign dn_rom_addr_2 = {iter_q, dn_in ? page[DN_PAGE_ADDR_BW-1:0] : {DN_PAGE_ADDR_BW{1'b1}}};

  ib_rom_rd_align #(
    .W  (4 + VN_PAGE_ADDR_BW),
    .LAT(ROM_RD_LATENCY)
  ) u_align (
    .clk(write_clk),
    .rst(rst),
    .d  ({ld & dn_in, ld, ld, ~rd_bank, page}),
    .q  ({ib_ram_we, bank_d, page_d})
  );

  assign page_addr_ram_0   = {bank_d, page_d};
  assign page_addr_ram_1   = {bank_d, page_d};
  assign page_addr_ram_2   = {bank_d, page_d[DN_PAGE_ADDR_BW-1:0]};
  assign ram_write_dataA_0 = ib_ram_we[0] ? vn_rom_data_0 : '0;
  assign ram_write_dataA_1 = ib_ram_we[1] ? vn_rom_data_1 : '0;
  assign ram_write_dataA_2 = ib_ram_we[2] ? dn_rom_data_2 : '0;

`ifdef IB_LOADER_OVERRUN_CNT_EN
  always_ff @(posedge write_clk)
    if (rst) ovr_cnt <= '0;
    else if (load_req && state != IDLE && ovr_cnt != 8'hff) ovr_cnt <= ovr_cnt + 8'd1;
`endif
endmodule

// File: tb/tb_ib_ram_page_loader.sv
// tb_ib_ram_page_loader: scoreboard bench over three loader configurations sharing one stimulus stream
module tb_ib_ram_page_loader;
  import ib_loader_pkg::*;

  typedef struct {
    int         t;
    int         p;
    logic       b;
    logic [2:0] we;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] d2;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_req = 1'b0;
  logic [4:0] load_iter = '0;
  int         ecnt = 0;
  int         errs = 0;
  int         checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, act, exp, ecnt);
    end
  endtask

  function automatic logic [7:0] f0(input logic [10:0] a);
    return a[7:0] ^ {a[10:8], 5'h0b};
  endfunction

  function automatic logic [1:0] f2(input logic [10:0] a);
    return a[1:0] ^ a[7:6] ^ a[9:8];
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L  = g == 0 ? 2 : (g == 1 ? 4 : 1);
    localparam int DB = g == 1 ? 4 : 6;
    localparam int NV = 64;
    localparam int ND = 1 << DB;

    logic          load_busy, load_done, rd_bank;
    logic [10:0]   vra0, vra1;
    logic [4+DB:0] dra;
    logic [7:0]    vd0, vd1, wd0, wd1;
    logic [1:0]    dd, wd2;
    logic [6:0]    pa0, pa1;
    logic [DB:0]   pa2;
    logic [2:0]    we;
    logic [10:0]   h0 [L];
    logic [10:0]   h1 [L];
    logic [10:0]   h2 [L];
`ifdef IB_LOADER_OVERRUN_CNT_EN
    logic [7:0]    ovr_cnt;
`endif

    ib_ram_page_loader #(
      .DN_PAGE_ADDR_BW(DB),
      .DN_ROM_ADDR_BW (5 + DB),
      .ROM_RD_LATENCY (L)
    ) dut (
      .write_clk        (clk),
      .rst              (rst),
      .load_req         (load_req),
      .load_iter        (load_iter),
      .load_busy        (load_busy),
      .load_done        (load_done),
      .rd_bank          (rd_bank),
      .vn_rom_addr_0    (vra0),
      .vn_rom_addr_1    (vra1),
      .dn_rom_addr_2    (dra),
      .vn_rom_data_0    (vd0),
      .vn_rom_data_1    (vd1),
      .dn_rom_data_2    (dd),
      .page_addr_ram_0  (pa0),
      .page_addr_ram_1  (pa1),
      .page_addr_ram_2  (pa2),
      .ram_write_dataA_0(wd0),
      .ram_write_dataA_1(wd1),
      .ram_write_dataA_2(wd2),
      .ib_ram_we        (we)
`ifdef IB_LOADER_OVERRUN_CNT_EN
      ,.ovr_cnt         (ovr_cnt)
`endif
    );

    always @(posedge clk) begin
      h0[0] <= vra0;
      h1[0] <= vra1;
      h2[0] <= 11'(dra);
      for (int i = 1; i < L; i++) begin
        h0[i] <= h0[i-1];
        h1[i] <= h1[i-1];
        h2[i] <= h2[i-1];
      end
    end
    assign vd0 = f0(h0[L-1]);
    assign vd1 = ~f0(h1[L-1]);
    assign dd  = f2(h2[L-1]);

    int         e_s = -1000;
    int         done_at = -1;
    int         ovr_m = 0;
    logic       bank_m = 1'b0;
    logic       rst_q = 1'b0;
    logic [4:0] iter_m = '0;
    wr_t        q[$];

    always @(negedge clk) begin
      int          x;
      int          p;
      wr_t         w;
      logic [10:0] a;
      logic [10:0] da;
      x = ecnt;
      check($sformatf("d%0d_busy", g), 64'(load_busy), 64'(x >= e_s && x <= e_s + NV + L));
      check($sformatf("d%0d_done", g), 64'(load_done), 64'(x == done_at));
      check($sformatf("d%0d_rd_bank", g), 64'(rd_bank), 64'(bank_m));
`ifdef IB_LOADER_OVERRUN_CNT_EN
      check($sformatf("d%0d_ovr_cnt", g), 64'(ovr_cnt), 64'(ovr_m));
`endif
      if (rst_q)
        check($sformatf("d%0d_rst_addr", g), 64'({vra0, vra1, dra, pa0, pa1, pa2, wd0, wd1, wd2}), 64'(0));
      if (x >= e_s && x < e_s + NV) begin
        p = x - e_s;
        check($sformatf("d%0d_vn_addr0", g), 64'(vra0), 64'({iter_m, 6'(p)}));
        check($sformatf("d%0d_vn_addr1", g), 64'(vra1), 64'({iter_m, 6'(p)}));
        check($sformatf("d%0d_dn_addr", g), 64'(dra), 64'({iter_m, DB'(p < ND ? p : ND - 1)}));
      end
      if (q.size() > 0 && q[0].t == x) begin
        w = q.pop_front();
        check($sformatf("d%0d_we_p%0d", g, w.p), 64'(we), 64'(w.we));
        check($sformatf("d%0d_pa0_p%0d", g, w.p), 64'(pa0), 64'({w.b, 6'(w.p)}));
        check($sformatf("d%0d_pa1_p%0d", g, w.p), 64'(pa1), 64'({w.b, 6'(w.p)}));
        if (w.we[2]) check($sformatf("d%0d_pa2_p%0d", g, w.p), 64'(pa2), 64'({w.b, DB'(w.p)}));
        check($sformatf("d%0d_wd0_p%0d", g, w.p), 64'(wd0), 64'(w.d0));
        check($sformatf("d%0d_wd1_p%0d", g, w.p), 64'(wd1), 64'(w.d1));
        check($sformatf("d%0d_wd2_p%0d", g, w.p), 64'(wd2), 64'(w.d2));
      end else check($sformatf("d%0d_idle_we", g), 64'(we), 64'(0));
      rst_q = rst;
      if (rst) begin
        q.delete();
        e_s     = -1000;
        done_at = -1;
        bank_m  = 1'b0;
        ovr_m   = 0;
      end else begin
        if (x == done_at) bank_m = ~bank_m;
        if (load_req) begin
          if (x >= e_s && x <= e_s + NV + L) ovr_m = ovr_m == 255 ? 255 : ovr_m + 1;
          else begin
            e_s     = x + 1;
            iter_m  = load_iter;
            done_at = e_s + NV + L;
            for (int k = 0; k < NV; k++) begin
              a  = {load_iter, 6'(k)};
              da = 11'({load_iter, DB'(k < ND ? k : ND - 1)});
              w.t  = e_s + k + L;
              w.p  = k;
              w.b  = ~bank_m;
              w.we = {k < ND, 2'b11};
              w.d0 = f0(a);
              w.d1 = ~f0(a);
              w.d2 = k < ND ? f2(da) : 2'b00;
              q.push_back(w);
            end
          end
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse(input logic [4:0] i);
    load_req  = 1'b1;
    load_iter = i;
    @(posedge clk);
    #2;
    load_req = 1'b0;
  endtask

  initial begin
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(2);
    pulse(5'd3);
    wait_cyc(80);
    pulse(5'd4);
    wait_cyc(80);
    pulse(5'd7);
    wait_cyc(9);
    pulse(5'd1);
    wait_cyc(56);
    pulse(5'd2);
    wait_cyc(80);
    pulse(5'd9);
    wait_cyc(29);
    rst = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(5);
    pulse(5'd31);
    wait_cyc(80);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
